// File: rtl/clk_div_ratio_ctrl.sv
// ----------------------------------------------------------------------------
// clk_div_ratio_ctrl
//  Control stage in front of the integer clock divider, i_ref_clk domain.
//  It accepts ratio/enable change requests over valid/ready, rejects illegal
//  ratios and sequences the divider controls glitch-safely:
//  quiesce -> load ratio -> re-enable -> settle -> acknowledge.
//  The divider never sees o_div_ratio change while o_clk_en is high.
//
// Ports
//  i_ref_clk    in   1        reference clock (same clock as divider)
//  i_rst        in   1        asynchronous reset, active-high
//  i_req_valid  in   1        change request valid
//  o_req_ready  out  1        request accepted when valid & ready at posedge
//  i_req_ratio  in   RATIO_W  requested divide ratio
//  i_req_en     in   1        requested divider enable
//  o_ack_valid  out  1        one-cycle completion pulse
//  o_ack_err    out  1        qualifies o_ack_valid: 1 = request rejected
//  o_div_ratio  out  RATIO_W  to divider i_div_ratio
//  o_clk_en     out  1        to divider i_clk_en
//  o_busy       out  1        high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module clk_div_ratio_ctrl #(
   parameter int unsigned RATIO_W    = 8,
   parameter int unsigned RST_RATIO  = 2,
   parameter int unsigned QUIET_CYC  = 8,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic               i_ref_clk,
   input  logic               i_rst,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic [RATIO_W-1:0] i_req_ratio,
   input  logic               i_req_en,
   output logic               o_ack_valid,
   output logic               o_ack_err,
   output logic [RATIO_W-1:0] o_div_ratio,
   output logic               o_clk_en,
   output logic               o_busy
);

   localparam int unsigned MAX_CYC   = (QUIET_CYC > SETTLE_CYC) ? QUIET_CYC : SETTLE_CYC;
   localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1);
   // Counters are loaded with (cycles - 1) on state entry and exit at zero.
   localparam int unsigned QUIET_LD  = QUIET_CYC - 1;
   localparam int unsigned SETTLE_LD = (SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      QUIESCE = 3'd1,
      LOAD    = 3'd2,
      RESUME  = 3'd3,
      SETTLE  = 3'd4,
      ACK     = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RATIO_W-1:0] cap_ratio_q, cap_ratio_d;
   logic               cap_en_q, cap_en_d;
   logic [RATIO_W-1:0] div_ratio_d;
   logic               clk_en_d;
   logic               ack_valid_d;
   logic               ack_err_d;
   logic               req_ready_d;
   logic               busy_d;

   // State and all registered outputs
   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cap_ratio_q <= '0;
         cap_en_q    <= 1'b0;
         o_div_ratio <= RATIO_W'(RST_RATIO);
         o_clk_en    <= 1'b0;
         o_ack_valid <= 1'b0;
         o_ack_err   <= 1'b0;
         o_req_ready <= 1'b1;
         o_busy      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_ratio_q <= cap_ratio_d;
         cap_en_q    <= cap_en_d;
         o_div_ratio <= div_ratio_d;
         o_clk_en    <= clk_en_d;
         o_ack_valid <= ack_valid_d;
         o_ack_err   <= ack_err_d;
         o_req_ready <= req_ready_d;
         o_busy      <= busy_d;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_ratio_d = cap_ratio_q;
      cap_en_d    = cap_en_q;
      div_ratio_d = o_div_ratio;
      clk_en_d    = o_clk_en;
      ack_valid_d = 1'b0;
      ack_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               cap_ratio_d = i_req_ratio;
               cap_en_d    = i_req_en;
               if (i_req_en && (i_req_ratio < RATIO_W'(2))) begin
                  // Enabling with ratio 0/1 is rejected; divider untouched.
                  state_d     = ACK;
                  ack_valid_d = 1'b1;
                  ack_err_d   = 1'b1;
               end else if ((i_req_ratio == o_div_ratio) && (i_req_en == o_clk_en)) begin
                  state_d     = ACK;
                  ack_valid_d = 1'b1;
               end else if (o_clk_en) begin
                  // Stop the divider before its ratio is touched.
                  state_d  = QUIESCE;
                  clk_en_d = 1'b0;
                  cnt_d    = CNT_W'(QUIET_LD);
               end else begin
                  state_d = LOAD;
               end
            end
         end
         QUIESCE: begin
            if (cnt_q == '0) begin
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         LOAD: begin
            div_ratio_d = cap_ratio_q;
            state_d     = RESUME;
         end
         RESUME: begin
            // Enable rises one edge after the ratio update.
            clk_en_d = cap_en_q;
            if (cap_en_q && (SETTLE_CYC > 0)) begin
               state_d = SETTLE;
               cnt_d   = CNT_W'(SETTLE_LD);
            end else begin
               state_d     = ACK;
               ack_valid_d = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d     = ACK;
               ack_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_div_ratio_ctrl
//  Directed bench for clk_div_ratio_ctrl with default parameters
//  (RATIO_W=8, RST_RATIO=2, QUIET_CYC=8, SETTLE_CYC=2). Outputs are sampled
//  1 time unit after the rising edge; inputs change on the falling edge.
// ----------------------------------------------------------------------------
module tb_clk_div_ratio_ctrl;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_ratio;
   logic       req_en;
   logic       ack_valid;
   logic       ack_err;
   logic [7:0] div_ratio;
   logic       clk_en;
   logic       busy;

   int checks = 0;
   int errors = 0;

   clk_div_ratio_ctrl #(
      .RATIO_W    (8),
      .RST_RATIO  (2),
      .QUIET_CYC  (8),
      .SETTLE_CYC (2)
   ) dut (
      .i_ref_clk   (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_ratio (req_ratio),
      .i_req_en    (req_en),
      .o_ack_valid (ack_valid),
      .o_ack_err   (ack_err),
      .o_div_ratio (div_ratio),
      .o_clk_en    (clk_en),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider safety: ratio never changes while enable is high before or after the edge.
   logic [7:0] mon_ratio;
   logic       mon_en;
   logic       mon_rst;
   always @(negedge clk) begin
      if (!rst && !mon_rst && (div_ratio !== mon_ratio)) begin
         checks++;
         if (mon_en === 1'b1 || clk_en === 1'b1) begin
            errors++;
            $display("FAIL ratio_while_enabled: ratio %0d->%0d en_before=%b en_after=%b want both 0",
                     mon_ratio, div_ratio, mon_en, clk_en);
         end
      end
      mon_ratio = div_ratio;
      mon_en    = clk_en;
      mon_rst   = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request and returns 1 unit after the accepting edge E0.
   // With hold=1, valid stays high and the fields switch to (nr, ne).
   task automatic do_req(input logic [7:0] r, input logic e, input logic hold,
                         input logic [7:0] nr, input logic ne);
      int t;
      t = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_ratio = r;
      req_en    = e;
      while (req_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout: ready=%b want 1", req_ready);
      end
      tick();
      if (hold) begin
         req_ratio = nr;
         req_en    = ne;
      end else begin
         req_valid = 1'b0;
         req_ratio = 8'hA5;
         req_en    = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      req_valid = 1'b0;
      req_ratio = 8'd0;
      req_en    = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (div_ratio !== 8'd2 || clk_en !== 1'b0 || req_ready !== 1'b1 ||
          busy !== 1'b0 || ack_valid !== 1'b0 || ack_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: ratio=%0d en=%b ready=%b busy=%b ack=%b err=%b want 2 0 1 0 0 0",
                  div_ratio, clk_en, req_ready, busy, ack_valid, ack_err);
      end
      tick();
      tick();
      #2 rst = 1'b0;
   endtask

   task automatic test_from_disabled();
      do_req(8'd6, 1'b1, 1'b0, 8'd0, 1'b0);
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0 || div_ratio !== 8'd2 || clk_en !== 1'b0) begin
         errors++;
         $display("FAIL dis_e0: busy=%b ready=%b ratio=%0d en=%b want 1 0 2 0", busy, req_ready, div_ratio, clk_en);
      end
      tick();
      checks++;
      if (div_ratio !== 8'd6 || clk_en !== 1'b0) begin
         errors++;
         $display("FAIL dis_e1: ratio=%0d en=%b want 6 0", div_ratio, clk_en);
      end
      tick();
      checks++;
      if (clk_en !== 1'b1 || ack_valid !== 1'b0) begin
         errors++;
         $display("FAIL dis_e2: en=%b ack=%b want 1 0", clk_en, ack_valid);
      end
      tick();
      checks++;
      if (ack_valid !== 1'b0) begin
         errors++;
         $display("FAIL dis_e3_ack: ack=%b want 0", ack_valid);
      end
      tick();
      checks++;
      if (ack_valid !== 1'b1 || ack_err !== 1'b0 || div_ratio !== 8'd6 || clk_en !== 1'b1) begin
         errors++;
         $display("FAIL dis_e4_ack: ack=%b err=%b ratio=%0d en=%b want 1 0 6 1", ack_valid, ack_err, div_ratio, clk_en);
      end
      tick();
      checks++;
      if (ack_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL dis_e5_idle: ack=%b ready=%b busy=%b want 0 1 0", ack_valid, req_ready, busy);
      end
   endtask

   task automatic test_ratio_change();
      logic bad;
      bad = 1'b0;
      do_req(8'd5, 1'b1, 1'b0, 8'd0, 1'b0);
      checks++;
      if (clk_en !== 1'b0 || div_ratio !== 8'd6) begin
         errors++;
         $display("FAIL chg_e0: en=%b ratio=%0d want 0 6", clk_en, div_ratio);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (clk_en !== 1'b0 || div_ratio !== 8'd6 || ack_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL chg_quiesce: en/ratio/ack moved during quiesce, got bad=%b want 0", bad);
      end
      tick();
      checks++;
      if (div_ratio !== 8'd5 || clk_en !== 1'b0) begin
         errors++;
         $display("FAIL chg_e9: ratio=%0d en=%b want 5 0", div_ratio, clk_en);
      end
      tick();
      checks++;
      if (clk_en !== 1'b1) begin
         errors++;
         $display("FAIL chg_e10: en=%b want 1", clk_en);
      end
      tick();
      tick();
      checks++;
      if (ack_valid !== 1'b1 || ack_err !== 1'b0) begin
         errors++;
         $display("FAIL chg_e12_ack: ack=%b err=%b want 1 0", ack_valid, ack_err);
      end
      tick();
   endtask

   task automatic test_illegal_noop();
      do_req(8'd1, 1'b1, 1'b0, 8'd0, 1'b0);
      checks++;
      if (ack_valid !== 1'b1 || ack_err !== 1'b1 || div_ratio !== 8'd5 || clk_en !== 1'b1) begin
         errors++;
         $display("FAIL illegal_ack: ack=%b err=%b ratio=%0d en=%b want 1 1 5 1", ack_valid, ack_err, div_ratio, clk_en);
      end
      tick();
      checks++;
      if (ack_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL illegal_done: ack=%b ready=%b want 0 1", ack_valid, req_ready);
      end
      // Disable with ratio 0 from the running state: quiesce path, n = 10.
      do_req(8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      for (int k = 1; k <= 9; k++) tick();
      checks++;
      if (div_ratio !== 8'd0 || clk_en !== 1'b0 || ack_valid !== 1'b0) begin
         errors++;
         $display("FAIL dis0_e9: ratio=%0d en=%b ack=%b want 0 0 0", div_ratio, clk_en, ack_valid);
      end
      tick();
      checks++;
      if (ack_valid !== 1'b1 || ack_err !== 1'b0 || clk_en !== 1'b0) begin
         errors++;
         $display("FAIL dis0_e10_ack: ack=%b err=%b en=%b want 1 0 0", ack_valid, ack_err, clk_en);
      end
      tick();
      // Resend current settings: immediate ack, nothing moves.
      do_req(8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      checks++;
      if (ack_valid !== 1'b1 || ack_err !== 1'b0 || clk_en !== 1'b0 || div_ratio !== 8'd0) begin
         errors++;
         $display("FAIL noop_ack: ack=%b err=%b en=%b ratio=%0d want 1 0 0 0", ack_valid, ack_err, clk_en, div_ratio);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic bad;
      bad = 1'b0;
      do_req(8'd3, 1'b1, 1'b0, 8'd0, 1'b0);
      for (int k = 1; k <= 4; k++) tick();
      checks++;
      if (ack_valid !== 1'b1 || div_ratio !== 8'd3 || clk_en !== 1'b1) begin
         errors++;
         $display("FAIL b2b_setup: ack=%b ratio=%0d en=%b want 1 3 1", ack_valid, div_ratio, clk_en);
      end
      tick();
      // First request 4, then hold valid with a second request 7 behind it.
      do_req(8'd4, 1'b1, 1'b1, 8'd7, 1'b1);
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (req_ready !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL b2b_ready_low: ready rose while busy, got bad=%b want 0", bad);
      end
      tick();
      checks++;
      if (ack_valid !== 1'b1 || req_ready !== 1'b0 || div_ratio !== 8'd4) begin
         errors++;
         $display("FAIL b2b_first_ack: ack=%b ready=%b ratio=%0d want 1 0 4", ack_valid, req_ready, div_ratio);
      end
      tick();
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: ready=%b busy=%b want 1 0", req_ready, busy);
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1 || clk_en !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_accept: ready=%b busy=%b en=%b want 0 1 0", req_ready, busy, clk_en);
      end
   endtask

   task automatic test_reset_abort();
      int acks;
      acks = 0;
      // Continues the second request: E0 was the last edge.
      for (int k = 1; k <= 10; k++) tick();
      checks++;
      if (div_ratio !== 8'd7 || clk_en !== 1'b1 || ack_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_pre: ratio=%0d en=%b ack=%b want 7 1 0", div_ratio, clk_en, ack_valid);
      end
      tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (div_ratio !== 8'd2 || clk_en !== 1'b0 || ack_valid !== 1'b0 ||
          busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_reset: ratio=%0d en=%b ack=%b busy=%b ready=%b want 2 0 0 0 1",
                  div_ratio, clk_en, ack_valid, busy, req_ready);
      end
      tick();
      #2 rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (ack_valid !== 1'b0) acks++;
      end
      checks++;
      if (acks != 0 || clk_en !== 1'b0 || div_ratio !== 8'd2) begin
         errors++;
         $display("FAIL abort_no_ack: acks=%0d en=%b ratio=%0d want 0 0 2", acks, clk_en, div_ratio);
      end
   endtask

   initial begin
      test_reset();
      test_from_disabled();
      test_ratio_change();
      test_illegal_noop();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
